// File: rtl/wb_pkg.sv
// Shared encodings for the writeback path: writeback-mux selects and
// register-file write-port arbiter states.
package wb_pkg;

  localparam int WB_REGW = 5;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  typedef enum logic [1:0] {
    ARB_EMPTY   = 2'd0,
    ARB_PENDING = 2'd1,
    ARB_FORCE   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_hold_reg.sv
// One-entry holding register for a long-latency result (rd + data).
// clear wins over load; both are cleared by the synchronous reset.
module wb_hold_reg #(
  parameter int DATAW = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [REGW-1:0]  load_rd,
  input  logic [DATAW-1:0] load_data,
  output logic             valid,
  output logic [REGW-1:0]  rd,
  output logic [DATAW-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      rd    <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      rd    <= load_rd;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the WB stage and a
// long-latency unit. Define WB_LL_BYPASS_EN to let LL results skip the buffer
// when the port is idle.
//
// state       | meaning
// ARB_EMPTY   | buffer free, LL accepted, pipeline has the port
// ARB_PENDING | LL result buffered, waiting for a free port cycle
// ARB_FORCE   | buffered result starved, written now, pipeline stalled
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DATAW    = 32,
  parameter int REGW     = WB_REGW,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_we,
  input  logic [REGW-1:0]  pipe_rd,
  input  logic [DATAW-1:0] pipe_data,
  output logic             pipe_stall,
  input  logic             ll_valid,
  input  logic [REGW-1:0]  ll_rd,
  input  logic [DATAW-1:0] ll_data,
  output logic             ll_ready,
  output logic             rf_we,
  output logic [REGW-1:0]  rf_waddr,
  output logic [DATAW-1:0] rf_wdata,
  output logic             pend_valid,
  output logic [REGW-1:0]  pend_rd
);

  localparam int CNTW = $clog2(MAX_WAIT + 1);

  arb_state_t state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic pipe_wants, ll_keep;
  logic grant_pipe, grant_buf, grant_ll;
  logic hold_load, hold_clear;
  logic [REGW-1:0]  hold_rd;
  logic [DATAW-1:0] hold_data;

  assign pipe_wants = pipe_we & (pipe_rd != '0);
  assign ll_ready   = (state_q == ARB_EMPTY) & ~rst;
  // x0 results are accepted but never stored or written
  assign ll_keep    = ll_valid & ll_ready & (ll_rd != '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_pipe = 1'b0;
    grant_buf  = 1'b0;
    grant_ll   = 1'b0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    pipe_stall = 1'b0;
    case (state_q)
      ARB_EMPTY: begin
        cnt_d      = '0;
        grant_pipe = pipe_wants;
`ifdef WB_LL_BYPASS_EN
        if (ll_keep && !pipe_wants) begin
          grant_ll = 1'b1;
        end else if (ll_keep) begin
          hold_load = 1'b1;
          state_d   = ARB_PENDING;
        end
`else
        if (ll_keep) begin
          hold_load = 1'b1;
          state_d   = ARB_PENDING;
        end
`endif
      end
      ARB_PENDING: begin
        if (pipe_wants) begin
          grant_pipe = 1'b1;
          if (cnt_q != CNTW'(MAX_WAIT)) cnt_d = cnt_q + CNTW'(1);
          if (cnt_d == CNTW'(MAX_WAIT)) state_d = ARB_FORCE;
        end else begin
          grant_buf  = 1'b1;
          hold_clear = 1'b1;
          cnt_d      = '0;
          state_d    = ARB_EMPTY;
        end
      end
      ARB_FORCE: begin
        grant_buf  = 1'b1;
        hold_clear = 1'b1;
        pipe_stall = pipe_wants;
        cnt_d      = '0;
        state_d    = ARB_EMPTY;
      end
      default: begin
        cnt_d   = '0;
        state_d = ARB_EMPTY;
      end
    endcase
    if (rst) pipe_stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_EMPTY;
      cnt_q    <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rf_we   <= grant_pipe | grant_buf | grant_ll;
      if (grant_pipe) begin
        rf_waddr <= pipe_rd;
        rf_wdata <= pipe_data;
      end else if (grant_buf) begin
        rf_waddr <= hold_rd;
        rf_wdata <= hold_data;
      end else if (grant_ll) begin
        rf_waddr <= ll_rd;
        rf_wdata <= ll_data;
      end else begin
        rf_waddr <= '0;
        rf_wdata <= '0;
      end
    end
  end

  wb_hold_reg #(
    .DATAW(DATAW),
    .REGW (REGW)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .clear    (hold_clear),
    .load_rd  (ll_rd),
    .load_data(ll_data),
    .valid    (pend_valid),
    .rd       (hold_rd),
    .data     (hold_data)
  );

  assign pend_rd = hold_rd;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus a randomized run against
// a buffer/denial-count reference model. Honours WB_LL_BYPASS_EN.
module tb_wb_port_arbiter;

  localparam int MAX_WAIT = 4;
`ifdef WB_LL_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        ll_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pend_valid;
  logic [4:0]  pend_rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATAW(32), .REGW(5), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_valid(pend_valid), .pend_rd(pend_rd)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
    ll_valid = 1'b0; ll_rd = '0; ll_data = '0;
  endtask

  task automatic drain;
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    repeat (2) tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf_addr_data got=%0d/%h exp=0/0", rf_waddr, rf_wdata); end
    checks++; if (pend_valid !== 1'b0 || pend_rd !== 5'd0) begin errors++; $display("FAIL reset_pend got=%b/%0d exp=0/0", pend_valid, pend_rd); end
    checks++; if (ll_ready !== 1'b0 || pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_ready_stall got=%b/%b exp=0/0", ll_ready, pipe_stall); end
    rst = 1'b0;
    #1;
    checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", ll_ready); end
  endtask

  task automatic test_pipe_write;
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'hA5;
    #1;
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL pipe_stall got=%b exp=0", pipe_stall); end
    tick();
    pipe_we = 1'b0;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hA5) begin
      errors++; $display("FAIL pipe_write got=%b/%0d/%h exp=1/3/a5", rf_we, rf_waddr, rf_wdata); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL pipe_write_once got=%b exp=0", rf_we); end
  endtask

  task automatic test_ll_buffer;
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h1234;
    #1;
    checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL ll_accept got=%b exp=1", ll_ready); end
    tick();
    ll_valid = 1'b0;
    if (BYPASS) begin
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h1234 || pend_valid !== 1'b0) begin
        errors++; $display("FAIL ll_bypass got=%b/%0d/%h pend=%b exp=1/7/1234 pend=0", rf_we, rf_waddr, rf_wdata, pend_valid); end
    end else begin
      checks++; if (ll_ready !== 1'b0 || pend_valid !== 1'b1 || pend_rd !== 5'd7 || rf_we !== 1'b0) begin
        errors++; $display("FAIL ll_pending got ready=%b pend=%b/%0d we=%b exp 0/1/7/0", ll_ready, pend_valid, pend_rd, rf_we); end
      tick();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h1234 || pend_valid !== 1'b0) begin
        errors++; $display("FAIL ll_drain got=%b/%0d/%h pend=%b exp=1/7/1234 pend=0", rf_we, rf_waddr, rf_wdata, pend_valid); end
    end
    drain();
  endtask

  task automatic test_starvation;
    logic [4:0] exp_seq [7] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd9, 5'd6};
    logic [4:0] got [$];
    int nxt = 1;
    int stalls = 0;
    for (int c = 0; c < 14; c++) begin
      pipe_we = (nxt <= 6); pipe_rd = 5'(nxt); pipe_data = 32'h100 + nxt;
      ll_valid = (c == 0); ll_rd = 5'd9; ll_data = 32'h900;
      #1;
      if (pipe_stall) stalls++;
      else if (nxt <= 6) nxt++;
      tick();
      if (rf_we) begin
        got.push_back(rf_waddr);
        checks++; if (rf_wdata !== ((rf_waddr == 5'd9) ? 32'h900 : 32'h100 + 32'(rf_waddr))) begin
          errors++; $display("FAIL starve_data rd=%0d got=%h", rf_waddr, rf_wdata); end
      end
    end
    checks++; if (stalls != 1) begin errors++; $display("FAIL starve_stall_cycles got=%0d exp=1", stalls); end
    checks++; if (got.size() != 7) begin errors++; $display("FAIL starve_write_count got=%0d exp=7", got.size()); end
    for (int k = 0; k < 7 && k < got.size(); k++) begin
      checks++; if (got[k] !== exp_seq[k]) begin errors++; $display("FAIL starve_order idx=%0d got=%0d exp=%0d", k, got[k], exp_seq[k]); end
    end
    drain();
  endtask

  task automatic test_collision;
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h55;
    ll_valid = 1'b1; ll_rd = 5'd5; ll_data = 32'h66;
    tick();
    idle_inputs();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h55 || pend_valid !== 1'b1 || pend_rd !== 5'd5) begin
      errors++; $display("FAIL collide_first got=%b/%0d/%h pend=%b/%0d exp=1/5/55 pend=1/5", rf_we, rf_waddr, rf_wdata, pend_valid, pend_rd); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h66 || pend_valid !== 1'b0) begin
      errors++; $display("FAIL collide_second got=%b/%0d/%h pend=%b exp=1/5/66 pend=0", rf_we, rf_waddr, rf_wdata, pend_valid); end
    drain();
  endtask

  task automatic test_x0;
    pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hDEAD;
    ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'hBEEF;
    #1;
    checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got=%b exp=1", ll_ready); end
    tick();
    idle_inputs();
    #1;
    checks++; if (rf_we !== 1'b0 || ll_ready !== 1'b1 || pend_valid !== 1'b0) begin
      errors++; $display("FAIL x0_nowrite got we=%b ready=%b pend=%b exp 0/1/0", rf_we, ll_ready, pend_valid); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_late got=%b exp=0", rf_we); end
  endtask

  task automatic reset_and_check(input string tag);
    rst = 1'b1;
    #1;
    checks++; if (ll_ready !== 1'b0 || pipe_stall !== 1'b0) begin
      errors++; $display("FAIL %s_during got ready=%b stall=%b exp 0/0", tag, ll_ready, pipe_stall); end
    tick();
    checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || pend_valid !== 1'b0 || pend_rd !== 5'd0) begin
      errors++; $display("FAIL %s_after got=%b/%0d/%h pend=%b/%0d exp all 0", tag, rf_we, rf_waddr, rf_wdata, pend_valid, pend_rd); end
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL %s_release got=%b exp=1", tag, ll_ready); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL %s_discard got=%b exp=0", tag, rf_we); end
  endtask

  task automatic test_reset_mid;
    pipe_we = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h1;
    ll_valid = 1'b1; ll_rd = 5'd11; ll_data = 32'hB;
    tick();
    ll_valid = 1'b0; pipe_rd = 5'd2;
    checks++; if (pend_valid !== 1'b1 || pend_rd !== 5'd11) begin
      errors++; $display("FAIL mid_pending got=%b/%0d exp=1/11", pend_valid, pend_rd); end
    reset_and_check("rst_pending");
    for (int c = 0; c < 5; c++) begin
      pipe_we = 1'b1; pipe_rd = 5'(c + 1); pipe_data = 32'(c);
      ll_valid = (c == 0); ll_rd = 5'd12; ll_data = 32'hC;
      tick();
    end
    ll_valid = 1'b0; pipe_we = 1'b1; pipe_rd = 5'd6;
    #1;
    checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL mid_force_stall got=%b exp=1", pipe_stall); end
    reset_and_check("rst_force");
  endtask

  task automatic test_random;
    bit m_buf = 1'b0;
    logic [4:0] m_rd = '0;
    logic [31:0] m_data = '0;
    int m_denied = 0;
    bit e_we = 1'b0;
    logic [4:0] e_addr = '0;
    logic [31:0] e_data = '0;
    bit hold_pipe = 1'b0;
    bit pw, e_ready, e_stall;
    idle_inputs();
    for (int i = 0; i < 800; i++) begin
      checks++; if (rf_we !== e_we || (e_we && (rf_waddr !== e_addr || rf_wdata !== e_data))) begin
        errors++; $display("FAIL rand_rf cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", i, rf_we, rf_waddr, rf_wdata, e_we, e_addr, e_data); end
      checks++; if (pend_valid !== m_buf || pend_rd !== (m_buf ? m_rd : 5'd0)) begin
        errors++; $display("FAIL rand_pend cyc=%0d got=%b/%0d exp=%b/%0d", i, pend_valid, pend_rd, m_buf, m_buf ? m_rd : 5'd0); end
      rst = ($urandom_range(0, 63) == 0);
      if (!hold_pipe) begin
        pipe_we = ($urandom_range(0, 2) != 0);
        pipe_rd = 5'($urandom_range(0, 7));
        pipe_data = $urandom;
      end
      ll_valid = ($urandom_range(0, 2) == 0);
      ll_rd = 5'($urandom_range(0, 7));
      ll_data = $urandom;
      #1;
      pw = pipe_we && (pipe_rd != 5'd0);
      e_ready = 1'b0; e_stall = 1'b0; e_we = 1'b0;
      if (rst) begin
        m_buf = 1'b0; m_rd = '0; m_denied = 0;
      end else if (!m_buf) begin
        e_ready = 1'b1;
        if (pw) begin e_we = 1'b1; e_addr = pipe_rd; e_data = pipe_data; end
        if (ll_valid && ll_rd != 5'd0) begin
          if (BYPASS && !pw) begin e_we = 1'b1; e_addr = ll_rd; e_data = ll_data; end
          else begin m_buf = 1'b1; m_rd = ll_rd; m_data = ll_data; m_denied = 0; end
        end
      end else if (m_denied >= MAX_WAIT) begin
        e_stall = pw;
        e_we = 1'b1; e_addr = m_rd; e_data = m_data; m_buf = 1'b0; m_rd = '0;
      end else if (pw) begin
        e_we = 1'b1; e_addr = pipe_rd; e_data = pipe_data; m_denied++;
      end else begin
        e_we = 1'b1; e_addr = m_rd; e_data = m_data; m_buf = 1'b0; m_rd = '0;
      end
      checks++; if (ll_ready !== e_ready || pipe_stall !== e_stall) begin
        errors++; $display("FAIL rand_comb cyc=%0d got ready=%b stall=%b exp %b/%b", i, ll_ready, pipe_stall, e_ready, e_stall); end
      hold_pipe = e_stall;
      tick();
    end
    rst = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_pipe_write();
    test_ll_buffer();
    test_starvation();
    test_collision();
    test_x0();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
